key_cmd_sched: RTL and testbench

KEY_CMD_SCHED -- requirements
Module: key_cmd_sched

---
 rtl/key_cmd_sched.sv | 157 +++++++++++++++
 tb/tb_key_cmd_sched.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_cmd_sched.sv
// rtl/key_cmd_sched.sv - round-robin key event to transmit command scheduler
module key_cmd_sched #(
    parameter int N_KEY       = 4,
    parameter int TIMEOUT_CYC = 1000,
    parameter int GAP_CYC     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_KEY-1:0] key_valid,
    output logic             tx_req,
    output logic [2:0]       tx_cmd,
    output logic [7:0]       tx_seq,
    input  logic             tx_ack,
    output logic [N_KEY-1:0] pend,
    output logic [7:0]       drop_cnt,
    output logic             timeout_err
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_GAP} state_t;

    localparam logic [15:0]      WAIT_LAST = 16'(TIMEOUT_CYC - 1);
    localparam logic [7:0]       GAP_LAST  = 8'(GAP_CYC - 1);
    localparam logic [2:0]       LAST_INIT = 3'(N_KEY - 1);
    localparam logic [N_KEY-1:0] ONE       = {{(N_KEY-1){1'b0}}, 1'b1};

    state_t             state_q, state_d;
    logic [N_KEY-1:0]   pend_q, pend_d;
    logic [7:0]         drop_cnt_q, drop_cnt_d;
    logic [2:0]         last_grant_q, last_grant_d;
    logic               tx_req_q, tx_req_d;
    logic [2:0]         tx_cmd_q, tx_cmd_d;
    logic [7:0]         tx_seq_q, tx_seq_d;
    logic               timeout_err_q, timeout_err_d;
    logic [15:0]        wait_q, wait_d;
    logic [7:0]         gap_q, gap_d;

    logic               grant_found;
    logic [2:0]         grant_idx;
    logic [3:0]         cand;
    logic [N_KEY-1:0]   grant_mask;
    logic [N_KEY-1:0]   drop_bits;
    logic [3:0]         n_drop;
    logic [8:0]         drop_sum;

    // Round-robin pick: first pending key scanning upward from last_grant+1, wrapping at N_KEY
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = 3'd0;
        cand        = 4'd0;
        for (int k = 1; k <= N_KEY; k++) begin
            cand = {1'b0, last_grant_q} + 4'(k);
            if (cand >= 4'(N_KEY)) begin
                cand = cand - 4'(N_KEY);
            end
            if (!grant_found && (|(pend_q & (ONE << cand)))) begin
                grant_found = 1'b1;
                grant_idx   = cand[2:0];
            end
        end
    end

    // Next-state: FSM sequencing, command fields, pending bitmap and saturating drop count
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        tx_req_d      = tx_req_q;
        tx_cmd_d      = tx_cmd_q;
        tx_seq_d      = tx_seq_q;
        timeout_err_d = 1'b0;
        wait_d        = wait_q;
        gap_d         = gap_q;
        grant_mask    = '0;

        case (state_q)
            S_IDLE: begin
                if (grant_found) begin
                    grant_mask   = ONE << grant_idx;
                    tx_cmd_d     = grant_idx;
                    tx_req_d     = 1'b1;
                    wait_d       = 16'd0;
                    last_grant_d = grant_idx;
                    state_d      = S_REQ;
                end
            end
            S_REQ: begin
                // An ack on the last allowed cycle takes priority over the abort
                if (tx_ack) begin
                    tx_req_d = 1'b0;
                    tx_seq_d = tx_seq_q + 8'd1;
                    gap_d    = 8'd0;
                    state_d  = S_GAP;
                end else if (wait_q == WAIT_LAST) begin
                    tx_req_d      = 1'b0;
                    timeout_err_d = 1'b1;
                    gap_d         = 8'd0;
                    state_d       = S_GAP;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A new event on the key being granted re-arms it rather than counting as lost
        drop_bits = key_valid & pend_q & ~grant_mask;
        pend_d    = (pend_q & ~grant_mask) | key_valid;

        n_drop = 4'd0;
        for (int i = 0; i < N_KEY; i++) begin
            n_drop = n_drop + {3'd0, drop_bits[i]};
        end
        drop_sum   = {1'b0, drop_cnt_q} + {5'd0, n_drop};
        drop_cnt_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    // State register with synchronous reset; inputs are ignored while reset is held
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            pend_q        <= '0;
            drop_cnt_q    <= 8'd0;
            last_grant_q  <= LAST_INIT;
            tx_req_q      <= 1'b0;
            tx_cmd_q      <= 3'd0;
            tx_seq_q      <= 8'd0;
            timeout_err_q <= 1'b0;
            wait_q        <= 16'd0;
            gap_q         <= 8'd0;
        end else begin
            state_q       <= state_d;
            pend_q        <= pend_d;
            drop_cnt_q    <= drop_cnt_d;
            last_grant_q  <= last_grant_d;
            tx_req_q      <= tx_req_d;
            tx_cmd_q      <= tx_cmd_d;
            tx_seq_q      <= tx_seq_d;
            timeout_err_q <= timeout_err_d;
            wait_q        <= wait_d;
            gap_q         <= gap_d;
        end
    end

    assign tx_req      = tx_req_q;
    assign tx_cmd      = tx_cmd_q;
    assign tx_seq      = tx_seq_q;
    assign pend        = pend_q;
    assign drop_cnt    = drop_cnt_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_key_cmd_sched.sv
// tb/tb_key_cmd_sched.sv - directed self-checking bench for key_cmd_sched
module tb_key_cmd_sched;

    localparam int N_KEY       = 4;
    localparam int TIMEOUT_CYC = 8;
    localparam int GAP_CYC     = 4;

    logic             clk;
    logic             rst;
    logic [N_KEY-1:0] key_valid;
    logic             tx_req;
    logic [2:0]       tx_cmd;
    logic [7:0]       tx_seq;
    logic             tx_ack;
    logic [N_KEY-1:0] pend;
    logic [7:0]       drop_cnt;
    logic             timeout_err;

    int n_chk;
    int n_fail;

    key_cmd_sched #(
        .N_KEY       (N_KEY),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .GAP_CYC     (GAP_CYC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_valid   (key_valid),
        .tx_req      (tx_req),
        .tx_cmd      (tx_cmd),
        .tx_seq      (tx_seq),
        .tx_ack      (tx_ack),
        .pend        (pend),
        .drop_cnt    (drop_cnt),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_req();
        for (int i = 0; i < 40; i++) begin
            if (tx_req) break;
            tick();
        end
        chk_eq("req_seen", 32'(tx_req), 32'd1);
    endtask

    task automatic serve(input logic [2:0] ecmd, input logic [7:0] eseq);
        wait_req();
        chk_eq("serve_cmd", 32'(tx_cmd), 32'(ecmd));
        chk_eq("serve_seq", 32'(tx_seq), 32'(eseq));
        tx_ack = 1'b1;
        tick();
        tx_ack = 1'b0;
        chk_eq("serve_req_drop", 32'(tx_req), 32'd0);
        chk_eq("serve_seq_inc", 32'(tx_seq), 32'(eseq + 8'd1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int hi;
        int pulses;
        n_chk     = 0;
        n_fail    = 0;
        rst       = 1'b1;
        key_valid = '0;
        tx_ack    = 1'b0;

        // Reset state, with inputs active during reset
        key_valid = 4'b1111;
        tx_ack    = 1'b1;
        do_reset();
        key_valid = '0;
        tx_ack    = 1'b0;
        chk_eq("rst_tx_req", 32'(tx_req), 32'd0);
        chk_eq("rst_tx_cmd", 32'(tx_cmd), 32'd0);
        chk_eq("rst_tx_seq", 32'(tx_seq), 32'd0);
        chk_eq("rst_pend", 32'(pend), 32'd0);
        chk_eq("rst_drop", 32'(drop_cnt), 32'd0);
        chk_eq("rst_terr", 32'(timeout_err), 32'd0);

        // Basic request and latency
        key_valid = 4'b0001;
        tick();
        key_valid = '0;
        chk_eq("basic_pend_t1", 32'(pend), 32'h1);
        chk_eq("basic_req_t1", 32'(tx_req), 32'd0);
        tick();
        chk_eq("basic_req_t2", 32'(tx_req), 32'd1);
        chk_eq("basic_cmd_t2", 32'(tx_cmd), 32'd0);
        chk_eq("basic_seq_t2", 32'(tx_seq), 32'd0);
        chk_eq("basic_pend_t2", 32'(pend), 32'h0);
        tick();
        chk_eq("basic_req_t3", 32'(tx_req), 32'd1);
        tick();
        chk_eq("basic_req_t4", 32'(tx_req), 32'd1);
        tx_ack = 1'b1;
        tick();
        tx_ack = 1'b0;
        chk_eq("basic_req_t5", 32'(tx_req), 32'd0);
        chk_eq("basic_seq_t5", 32'(tx_seq), 32'd1);
        key_valid = 4'b0010;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            key_valid = '0;
            n++;
            if (tx_req) break;
        end
        chk_eq("gap_latency", 32'(n), 32'd5);
        serve(3'd1, 8'd1);

        // Round-robin from reset
        do_reset();
        key_valid = 4'b1111;
        tick();
        key_valid = '0;
        chk_eq("rr_pend_all", 32'(pend), 32'hF);
        serve(3'd0, 8'd0);
        serve(3'd1, 8'd1);
        serve(3'd2, 8'd2);
        serve(3'd3, 8'd3);
        chk_eq("rr_pend_end", 32'(pend), 32'h0);

        // Drop counting while busy on key 1
        do_reset();
        key_valid = 4'b0010;
        tick();
        key_valid = '0;
        wait_req();
        for (int i = 0; i < 4; i++) begin
            key_valid = 4'b0100;
            tick();
        end
        key_valid = '0;
        chk_eq("drop_pend", 32'(pend), 32'h4);
        chk_eq("drop_cnt3", 32'(drop_cnt), 32'd3);
        serve(3'd1, 8'd0);
        serve(3'd2, 8'd1);
        chk_eq("drop_pend_clear", 32'(pend), 32'h0);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (tx_req) n++;
        end
        chk_eq("drop_single_cmd", 32'(n), 32'd0);
        for (int i = 0; i < 300; i++) begin
            key_valid = 4'b0100;
            tick();
        end
        key_valid = '0;
        chk_eq("drop_saturate", 32'(drop_cnt), 32'd255);

        // Timeout with no ack
        do_reset();
        key_valid = 4'b0001;
        tick();
        key_valid = '0;
        wait_req();
        hi     = 1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (tx_req) hi++;
            if (timeout_err) pulses++;
        end
        chk_eq("to_high_cycles", 32'(hi), 32'd8);
        chk_eq("to_err_pulses", 32'(pulses), 32'd1);
        chk_eq("to_seq_kept", 32'(tx_seq), 32'd0);

        // Ack on the final allowed cycle wins
        key_valid = 4'b0001;
        tick();
        key_valid = '0;
        wait_req();
        pulses = 0;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (timeout_err) pulses++;
        end
        chk_eq("late_ack_req8", 32'(tx_req), 32'd1);
        tx_ack = 1'b1;
        tick();
        tx_ack = 1'b0;
        if (timeout_err) pulses++;
        chk_eq("late_ack_req_off", 32'(tx_req), 32'd0);
        chk_eq("late_ack_no_err", 32'(pulses), 32'd0);
        chk_eq("late_ack_seq", 32'(tx_seq), 32'd1);

        // Re-arm of the key being serviced
        do_reset();
        key_valid = 4'b0010;
        tick();
        key_valid = '0;
        wait_req();
        key_valid = 4'b0010;
        tick();
        key_valid = '0;
        chk_eq("rearm_pend", 32'(pend), 32'h2);
        serve(3'd1, 8'd0);
        serve(3'd1, 8'd1);
        chk_eq("rearm_drop", 32'(drop_cnt), 32'd0);
        chk_eq("rearm_pend_end", 32'(pend), 32'h0);

        // Reset mid-REQ with keys still pending
        do_reset();
        key_valid = 4'b0010;
        tick();
        key_valid = '0;
        serve(3'd1, 8'd0);
        key_valid = 4'b1110;
        tick();
        key_valid = '0;
        wait_req();
        chk_eq("mid_cmd", 32'(tx_cmd), 32'd2);
        chk_eq("mid_pend", 32'(pend), 32'hA);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_eq("mid_rst_req", 32'(tx_req), 32'd0);
        chk_eq("mid_rst_pend", 32'(pend), 32'h0);
        chk_eq("mid_rst_seq", 32'(tx_seq), 32'd0);
        chk_eq("mid_rst_cmd", 32'(tx_cmd), 32'd0);
        key_valid = 4'b1000;
        tick();
        key_valid = '0;
        serve(3'd3, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
